// File: rtl/ram_block_copier.sv
// ram_block_copier
// ----------------
// Copies a block of 16-bit words inside an external single-port ram512.
// The RAM read port is combinational: ram_out reflects ram_address within the
// same cycle. Each copied word takes two cycles: a READ that captures ram_out,
// then a WRITE that stores it. Addresses are 9 bits and wrap modulo 512.
//
// Optional feature: define RAM_FILL_EN to enable fill mode. In fill mode the
// block writes fill_value to every destination word, one word per cycle.
// Without the macro, fill and fill_value are accepted but ignored, and every
// transfer is a copy.
//
// Handshake: start is a level sampled only while the block is idle. A transfer
// runs to completion (or until reset), and done pulses for exactly one cycle
// when it ends. busy is high only while words are being read or written.
// start is ignored at every other time. All request inputs are latched at the
// start edge, so later changes on them do not affect the running transfer.
//
// Ports:
//   clk         rising-edge clock, shared with the RAM
//   rst_n       asynchronous active-low reset
//   start       transfer request, sampled in IDLE only
//   src_addr    first source word address
//   dst_addr    first destination word address
//   count       word count, 0..512 (larger values saturate to 512)
//   fill        fill-mode select (RAM_FILL_EN only)
//   fill_value  fill word (RAM_FILL_EN only)
//   busy        high in READ and WRITE
//   done        one-cycle completion pulse
//   ram_address RAM address
//   ram_in      RAM write data
//   ram_load    RAM write enable
//   ram_out     RAM read data (combinational from ram_address)

module ram_block_copier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  src_addr,
  input  logic [8:0]  dst_addr,
  input  logic [9:0]  count,
  input  logic        fill,
  input  logic [15:0] fill_value,
  output logic        busy,
  output logic        done,
  output logic [8:0]  ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  src_ptr_q, src_ptr_d;
  logic [8:0]  dst_ptr_q, dst_ptr_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [15:0] data_q, data_d;
  logic        mode_q, mode_d;   // 1 = fill, 0 = copy

  logic [9:0]  count_sat;
  logic        fill_sel;

  assign count_sat = (count > 10'd512) ? 10'd512 : count;

`ifdef RAM_FILL_EN
  assign fill_sel = fill;
`else
  // Fill mode is compiled out: the fill port is kept but has no effect.
  logic unused_fill;
  assign fill_sel    = 1'b0;
  assign unused_fill = fill;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= 9'd0;
      dst_ptr_q   <= 9'd0;
      remaining_q <= 10'd0;
      data_q      <= 16'd0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    mode_d      = mode_q;
    busy        = 1'b0;
    done        = 1'b0;
    ram_address = 9'd0;
    ram_in      = 16'd0;
    ram_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d   = src_addr;
          dst_ptr_d   = dst_addr;
          remaining_d = count_sat;
          mode_d      = fill_sel;
          // The fill word is parked in data_q so WRITE drives ram_in from one
          // register in both modes and later fill_value changes are ignored.
          if (fill_sel) begin
            data_d = fill_value;
          end
          if (count_sat == 10'd0) begin
            state_d = S_DONE;
          end else if (fill_sel) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        busy        = 1'b1;
        ram_address = src_ptr_q;
        data_d      = ram_out;
        state_d     = S_WRITE;
      end

      S_WRITE: begin
        busy        = 1'b1;
        ram_address = dst_ptr_q;
        ram_in      = data_q;
        ram_load    = 1'b1;
        // 9-bit pointers wrap naturally from 511 to 0.
        src_ptr_d   = src_ptr_q + 9'd1;
        dst_ptr_d   = dst_ptr_q + 9'd1;
        remaining_d = remaining_q - 10'd1;
        if (remaining_q == 10'd1) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
